gate_sensor_decoder: RTL

Decodes the two optical beam sensors at the single-lane parking gate into direction-qualified car events. It emits one-cycle `carIn` / `carOut` pulses that drive the occupancy counter directly downstream. Raw sensor inputs are synchronised and optionally debounced. A direction state machine accepts only complete, ordered beam-break sequences; reversals, glitches and stalls produce no count.

---
 rtl/gate_pkg.sv | 30 +++
 rtl/sensor_debounce.sv | 60 ++++++
 rtl/gate_sensor_decoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the parking-gate sensor decoder: direction FSM
// states, the single-event encoding that keeps the output pulses mutually
// exclusive, and the filtered sensor-pair codes {a,b}.
package gate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IN1  = 3'd1,
    ST_IN2  = 3'd2,
    ST_IN3  = 3'd3,
    ST_OUT1 = 3'd4,
    ST_OUT2 = 3'd5,
    ST_OUT3 = 3'd6
  } gate_state_t;

  // At most one event per cycle, so carIn/carOut/abort can never overlap.
  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_IN    = 2'd1,
    EVT_OUT   = 2'd2,
    EVT_ABORT = 2'd3
  } gate_evt_t;

  // Sensor-pair codes, {a,b}; a = outer beam, b = inner beam, 1 = blocked.
  localparam logic [1:0] SENS_CLEAR = 2'b00;
  localparam logic [1:0] SENS_A     = 2'b10;
  localparam logic [1:0] SENS_AB    = 2'b11;
  localparam logic [1:0] SENS_B     = 2'b01;

endpackage

// File: rtl/sensor_debounce.sv
// One beam sensor: 2-FF synchroniser followed by an optional debouncer.
// Build option GATE_DEBOUNCE_EN: when defined, the filtered level only
// changes after DEBOUNCE_CYCLES consecutive cycles of disagreement; when
// undefined, the filtered level is the synchroniser output.
module sensor_debounce
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_filt
);

  logic r_sync1;
  logic r_sync2;

  // Synchronise the raw beam input into the clk domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GATE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;

  // Count disagreeing cycles; flip the filtered level on the cycle the count
  // reaches DEBOUNCE_CYCLES, and restart whenever the levels agree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_filt = r_filt;
`else
  assign o_filt = r_sync2;
`endif

endmodule

// File: rtl/gate_sensor_decoder.sv
// Parking-gate beam decoder: turns the outer (A) and inner (B) beam sensors
// into one-cycle carIn / carOut / abort pulses plus a busy flag.
// Build option GATE_DEBOUNCE_EN enables the per-sensor debouncers.
// The FSM reacts only when the filtered pair {a,b} changes, so a sequence
// left stalled or abandoned does not restart until the beams move again.
module gate_sensor_decoder
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensorA,
  input  logic sensorB,
  output logic carIn,
  output logic carOut,
  output logic abort,
  output logic busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  logic        w_a;
  logic        w_b;
  logic [1:0]  w_ab;
  gate_state_t r_state;
  gate_state_t w_next_state;
  gate_evt_t   w_evt;
  logic [1:0]  r_prev_ab;
  logic [TO_W-1:0] r_to_cnt;
  logic        r_car_in;
  logic        r_car_out;
  logic        r_abort;
  logic        r_busy;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sens_a (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (sensorA),
    .o_filt  (w_a)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sens_b (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (sensorB),
    .o_filt  (w_b)
  );

  assign w_ab = {w_a, w_b};

  // Next state and event: step on a pair change, otherwise watch the timeout.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_evt        = EVT_NONE;
    if (w_ab != r_prev_ab) begin
      case (r_state)
        ST_IDLE: begin
          if (w_ab == SENS_A)      w_next_state = ST_IN1;
          else if (w_ab == SENS_B) w_next_state = ST_OUT1;
        end
        ST_IN1: begin
          if (w_ab == SENS_AB)         w_next_state = ST_IN2;
          else if (w_ab == SENS_CLEAR) w_next_state = ST_IDLE;
          else begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_ABORT;
          end
        end
        ST_IN2: begin
          if (w_ab == SENS_B)      w_next_state = ST_IN3;
          else if (w_ab == SENS_A) w_next_state = ST_IN1;
          else begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_ABORT;
          end
        end
        ST_IN3: begin
          if (w_ab == SENS_CLEAR) begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_IN;
          end else if (w_ab == SENS_AB) begin
            w_next_state = ST_IN2;
          end else begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_ABORT;
          end
        end
        ST_OUT1: begin
          if (w_ab == SENS_AB)         w_next_state = ST_OUT2;
          else if (w_ab == SENS_CLEAR) w_next_state = ST_IDLE;
          else begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_ABORT;
          end
        end
        ST_OUT2: begin
          if (w_ab == SENS_A)      w_next_state = ST_OUT3;
          else if (w_ab == SENS_B) w_next_state = ST_OUT1;
          else begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_ABORT;
          end
        end
        ST_OUT3: begin
          if (w_ab == SENS_CLEAR) begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_OUT;
          end else if (w_ab == SENS_AB) begin
            w_next_state = ST_OUT2;
          end else begin
            w_next_state = ST_IDLE;
            w_evt        = EVT_ABORT;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_to_cnt == TO_LAST) begin
      w_next_state = ST_IDLE;
      w_evt        = EVT_ABORT;
    end
  end

  // State register and last-seen pair for change detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_prev_ab <= SENS_CLEAR;
    end else begin
      r_state   <= w_next_state;
      r_prev_ab <= w_ab;
    end
  end

  // Stall timer: restarts on any state change and while idle, saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE || w_next_state != r_state) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Registered outputs, updated on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_car_in  <= 1'b0;
      r_car_out <= 1'b0;
      r_abort   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_car_in  <= (w_evt == EVT_IN);
      r_car_out <= (w_evt == EVT_OUT);
      r_abort   <= (w_evt == EVT_ABORT);
      r_busy    <= (w_next_state != ST_IDLE);
    end
  end

  assign carIn  = r_car_in;
  assign carOut = r_car_out;
  assign abort  = r_abort;
  assign busy   = r_busy;

endmodule
